// File: rtl/agu_queue.sv
// agu_queue: address generation queue between the reservation station and
// the memory side.
//
// Each accepted memory op has its effective address (vj + a, wrapping
// modulo 2^ADDR_W) computed on entry. The address is stored together with
// the ROB tag and opcode in a small FIFO. Only the head entry is visible
// on the outputs:
//   - A head load is offered to the load buffer and stays stable until
//     that buffer accepts it.
//   - A head store is reported to the ROB for a single cycle and then
//     retires.
// Ops that are not memory ops, including NOP, are accepted and dropped.
//
// Optional feature (macro AGU_MISALIGN_CHECK_EN): misaligned halfword and
// word ops are tagged on entry. At the head, such an op is reported to the
// ROB with agu_rob_misalign_out=1 instead of being issued to the load
// buffer.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   rs_agu_*      : op input from the reservation station (valid/ready)
//   agu_lbuffer_* : load request to the load buffer (valid/ready)
//   agu_rob_*     : store address / fault report to the ROB
//   rob_agu_rst_in: flush
//   agu_count_out : occupancy
`ifndef AddressWidth
`define AddressWidth 32
`endif
`ifndef ROBWidth
`define ROBWidth 5
`endif
`ifndef InstTypeWidth
`define InstTypeWidth 6
`endif
`ifndef NOP
`define NOP 6'd0
`define LB  6'd11
`define LH  6'd12
`define LW  6'd13
`define LBU 6'd14
`define LHU 6'd15
`define SB  6'd16
`define SH  6'd17
`define SW  6'd18
`endif

module agu_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `AddressWidth,
  parameter int ROB_W  = `ROBWidth,
  parameter int OP_W   = `InstTypeWidth
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       rs_agu_valid_in,
  output logic                       rs_agu_ready_out,
  input  logic [ADDR_W-1:0]          rs_agu_a_in,
  input  logic [ADDR_W-1:0]          rs_agu_vj_in,
  input  logic [ROB_W-1:0]           rs_agu_dest_in,
  input  logic [OP_W-1:0]            rs_agu_opcode_in,
  output logic                       agu_lbuffer_valid_out,
  input  logic                       lbuffer_agu_ready_in,
  output logic [ADDR_W-1:0]          agu_lbuffer_a_out,
  output logic [ROB_W-1:0]           agu_lbuffer_dest_out,
  output logic [OP_W-1:0]            agu_lbuffer_opcode_out,
  output logic                       agu_rob_en_out,
  output logic [ROB_W-1:0]           agu_rob_h_out,
  output logic [ADDR_W-1:0]          agu_rob_address_out,
  output logic                       agu_rob_misalign_out,
  input  logic                       rob_agu_rst_in,
  output logic [$clog2(DEPTH):0]     agu_count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = PTR_W'(DEPTH) << 0 | (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ROB_W-1:0]  dest_q [DEPTH];
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic              mis_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op >= OP_W'(`LB)) && (op <= OP_W'(`LHU));
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op >= OP_W'(`SB)) && (op <= OP_W'(`SW));
  endfunction

  logic [ADDR_W-1:0] enq_addr;
  logic              enq_mis;
  logic              head_load, head_mis, empty, active, push, pop;

  assign enq_addr = rs_agu_vj_in + rs_agu_a_in;

`ifdef AGU_MISALIGN_CHECK_EN
  always_comb begin
    enq_mis = 1'b0;
    if (rs_agu_opcode_in == OP_W'(`LH) || rs_agu_opcode_in == OP_W'(`LHU) ||
        rs_agu_opcode_in == OP_W'(`SH))
      enq_mis = enq_addr[0];
    else if (rs_agu_opcode_in == OP_W'(`LW) || rs_agu_opcode_in == OP_W'(`SW))
      enq_mis = |enq_addr[1:0];
  end
  assign head_mis = mis_q[rd_ptr];
`else
  assign enq_mis  = 1'b0;
  assign head_mis = 1'b0;
`endif

  assign empty     = (count == '0);
  assign head_load = is_load(op_q[rd_ptr]);
  // Outputs may fire only when enabled, not flushing and holding an entry.
  assign active    = rdy_in && !rob_agu_rst_in && !empty;

  assign rs_agu_ready_out      = rdy_in && !rob_agu_rst_in && (count < FULL);
  assign agu_lbuffer_valid_out = active && head_load && !head_mis;
  // Anything at the head that is not a clean load goes to the ROB:
  // stores, and faulting ops when the alignment check is built in.
  assign agu_rob_en_out        = active && !(head_load && !head_mis);
  assign agu_rob_misalign_out  = agu_rob_en_out && head_mis;

  assign agu_lbuffer_a_out      = empty ? '0 : addr_q[rd_ptr];
  assign agu_lbuffer_dest_out   = empty ? '0 : dest_q[rd_ptr];
  assign agu_lbuffer_opcode_out = empty ? '0 : op_q[rd_ptr];
  assign agu_rob_h_out          = empty ? '0 : dest_q[rd_ptr];
  assign agu_rob_address_out    = empty ? '0 : addr_q[rd_ptr];
  assign agu_count_out          = count;

  assign push = rs_agu_valid_in && rs_agu_ready_out &&
                (is_load(rs_agu_opcode_in) || is_store(rs_agu_opcode_in));
  assign pop  = (agu_lbuffer_valid_out && lbuffer_agu_ready_in) || agu_rob_en_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        dest_q[i] <= '0;
        op_q[i]   <= '0;
        mis_q[i]  <= 1'b0;
      end
    end else if (rdy_in) begin
      if (rob_agu_rst_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          addr_q[wr_ptr] <= enq_addr;
          dest_q[wr_ptr] <= rs_agu_dest_in;
          op_q[wr_ptr]   <= rs_agu_opcode_in;
          mis_q[wr_ptr]  <= enq_mis;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agu_queue.sv
// Directed bench for agu_queue (DEPTH=4, 32-bit addresses).
// Inputs change 1 time unit after a rising edge; outputs are checked
// before the following edge.
`ifndef AddressWidth
`define AddressWidth 32
`endif
`ifndef ROBWidth
`define ROBWidth 5
`endif
`ifndef InstTypeWidth
`define InstTypeWidth 6
`endif
`ifndef NOP
`define NOP 6'd0
`define LB  6'd11
`define LH  6'd12
`define LW  6'd13
`define LBU 6'd14
`define LHU 6'd15
`define SB  6'd16
`define SH  6'd17
`define SW  6'd18
`endif

module tb_agu_queue;
  logic        clk = 1'b0;
  logic        rst, rdy, rs_valid, rs_ready, lb_valid, lb_ready;
  logic [31:0] rs_a, rs_vj, lb_a, rob_addr;
  logic [4:0]  rs_dest, lb_dest, rob_h;
  logic [5:0]  rs_op, lb_op;
  logic        rob_en, rob_mis, flush;
  logic [2:0]  count;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  agu_queue #(.DEPTH(4)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .rs_agu_valid_in(rs_valid), .rs_agu_ready_out(rs_ready),
    .rs_agu_a_in(rs_a), .rs_agu_vj_in(rs_vj), .rs_agu_dest_in(rs_dest),
    .rs_agu_opcode_in(rs_op),
    .agu_lbuffer_valid_out(lb_valid), .lbuffer_agu_ready_in(lb_ready),
    .agu_lbuffer_a_out(lb_a), .agu_lbuffer_dest_out(lb_dest),
    .agu_lbuffer_opcode_out(lb_op),
    .agu_rob_en_out(rob_en), .agu_rob_h_out(rob_h),
    .agu_rob_address_out(rob_addr), .agu_rob_misalign_out(rob_mis),
    .rob_agu_rst_in(flush), .agu_count_out(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] vj,
                       input logic [31:0] a, input logic [4:0] dest);
    rs_valid = v; rs_op = op; rs_vj = vj; rs_a = a; rs_dest = dest;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; lb_ready = 1'b0;
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_lb_valid", 32'(lb_valid), 32'd0);
    chk("rst_rob_en", 32'(rob_en), 32'd0);
    chk("rst_lb_a", lb_a, 32'd0);
    chk("rst_rob_h", 32'(rob_h), 32'd0);
    chk("rst_mis", 32'(rob_mis), 32'd0);
    chk("rst_ready", 32'(rs_ready), 32'd1);

    // Load: address 0x1000+0x10, held while stalled, popped on ready
    drive(1'b1, `LW, 32'h1000, 32'h10, 5'd3);
    tick();
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    #1;
    chk("lw_valid", 32'(lb_valid), 32'd1);
    chk("lw_addr", lb_a, 32'h1010);
    chk("lw_dest", 32'(lb_dest), 32'd3);
    chk("lw_op", 32'(lb_op), 32'(`LW));
    chk("lw_rob_en", 32'(rob_en), 32'd0);
    tick();
    chk("lw_stall_valid", 32'(lb_valid), 32'd1);
    chk("lw_stall_addr", lb_a, 32'h1010);
    lb_ready = 1'b1;
    tick();
    lb_ready = 1'b0;
    #1;
    chk("lw_pop_count", 32'(count), 32'd0);
    chk("lw_pop_valid", 32'(lb_valid), 32'd0);
    chk("empty_addr_zero", lb_a, 32'd0);

    // Store with address wraparound
    drive(1'b1, `SW, 32'hFFFF_FFFC, 32'h8, 5'd5);
    tick();
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    #1;
    chk("sw_rob_en", 32'(rob_en), 32'd1);
    chk("sw_h", 32'(rob_h), 32'd5);
    chk("sw_addr", rob_addr, 32'h4);
    chk("sw_lb_valid", 32'(lb_valid), 32'd0);
    chk("sw_mis", 32'(rob_mis), 32'd0);
    tick();
    chk("sw_once", 32'(rob_en), 32'd0);
    chk("sw_count", 32'(count), 32'd0);

    // Five loads into a stalled queue: only four fit
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, `LW, 32'h100 * i, 32'h0, 5'(i));
      #1;
      chk("fill_ready", 32'(rs_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(rs_ready), 32'd0);
    lb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_dest", 32'(lb_dest), 32'(i));
      chk("drain_addr", lb_a, 32'h100 * i);
      tick();
    end
    lb_ready = 1'b0;
    #1;
    chk("drain_count", 32'(count), 32'd0);

    // Flush with three entries and a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, `LB, 32'h40, 32'(i), 5'(i + 8));
      tick();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    #1;
    chk("flush_lb_valid", 32'(lb_valid), 32'd0);
    chk("flush_ready", 32'(rs_ready), 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid_after", 32'(lb_valid), 32'd0);
    chk("flush_rob_after", 32'(rob_en), 32'd0);

    // NOP is consumed without enqueue
    drive(1'b1, `NOP, 32'h1234, 32'h0, 5'd1);
    tick();
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    #1;
    chk("nop_count", 32'(count), 32'd0);

    // Strict order across a load then a store
    drive(1'b1, `LW, 32'h200, 32'h0, 5'd1);
    tick();
    drive(1'b1, `SW, 32'h300, 32'h4, 5'd2);
    tick();
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    #1;
    chk("order_head_load", 32'(lb_dest), 32'd1);
    chk("order_no_rob", 32'(rob_en), 32'd0);
    lb_ready = 1'b1;
    tick();
    lb_ready = 1'b0;
    #1;
    chk("order_store_en", 32'(rob_en), 32'd1);
    chk("order_store_h", 32'(rob_h), 32'd2);
    chk("order_store_addr", rob_addr, 32'h304);
    tick();
    chk("order_empty", 32'(count), 32'd0);

    // Simultaneous push and pop keeps the count; exercises pointer wrap
    drive(1'b1, `LW, 32'h10, 32'h0, 5'd4);
    tick();
    drive(1'b1, `LW, 32'h20, 32'h0, 5'd6);
    tick();
    lb_ready = 1'b1;
    drive(1'b1, `LW, 32'h30, 32'h0, 5'd7);
    tick();
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    lb_ready = 1'b0;
    #1;
    chk("pushpop_count", 32'(count), 32'd2);
    chk("pushpop_head", 32'(lb_dest), 32'd6);

    // rdy_in low freezes state and overrides flush
    rdy = 1'b0; lb_ready = 1'b1;
    #1;
    chk("frozen_valid", 32'(lb_valid), 32'd0);
    chk("frozen_ready", 32'(rs_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("frozen_count", 32'(count), 32'd2);
    rdy = 1'b1;
    tick(); tick();
    lb_ready = 1'b0;
    #1;
    chk("thaw_drain", 32'(count), 32'd0);

    // Misaligned halfword load
    drive(1'b1, `LH, 32'h1000, 32'h1, 5'd9);
    tick();
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    #1;
`ifdef AGU_MISALIGN_CHECK_EN
    chk("lh_mis_rob_en", 32'(rob_en), 32'd1);
    chk("lh_mis_flag", 32'(rob_mis), 32'd1);
    chk("lh_mis_lb_valid", 32'(lb_valid), 32'd0);
    chk("lh_mis_addr", rob_addr, 32'h1001);
    tick();
    chk("lh_mis_popped", 32'(count), 32'd0);
`else
    chk("lh_lb_valid", 32'(lb_valid), 32'd1);
    chk("lh_addr", lb_a, 32'h1001);
    chk("lh_mis_flag", 32'(rob_mis), 32'd0);
    chk("lh_rob_en", 32'(rob_en), 32'd0);
`endif

    // Reset wins over rdy_in low
    drive(1'b1, `SB, 32'h50, 32'h0, 5'd3);
    tick();
    drive(1'b0, `NOP, 32'h0, 32'h0, 5'd0);
    rdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; rdy = 1'b1;
    #1;
    chk("rst_over_rdy_count", 32'(count), 32'd0);
    chk("rst_over_rdy_ready", 32'(rs_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/agu_queue.md
AGU_QUEUE -- requirements
Module: agu_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter ADDR_W, default `AddressWidth, meaning address width.
REQ-003 The block SHALL have parameter ROB_W, default `ROBWidth, meaning ROB tag width.
REQ-004 The block SHALL have parameter OP_W, default `InstTypeWidth, meaning opcode width.
REQ-005 The block SHALL have these ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- rs_agu_valid_in  in  1  RS presents an op.
- rs_agu_ready_out  out  1  queue can accept.
- rs_agu_a_in  in  ADDR_W  immediate offset.
- rs_agu_vj_in  in  ADDR_W  base register value.
- rs_agu_dest_in  in  ROB_W  ROB tag.
- rs_agu_opcode_in  in  OP_W  instruction type.
- agu_lbuffer_valid_out  out  1  load request valid.
- lbuffer_agu_ready_in  in  1  load buffer accepts.
- agu_lbuffer_a_out  out  ADDR_W  load address.
- agu_lbuffer_dest_out  out  ROB_W  load tag.
- agu_lbuffer_opcode_out  out  OP_W  load opcode.
- agu_rob_en_out  out  1  store address (or fault) report valid.
- agu_rob_h_out  out  ROB_W  reported tag.
- agu_rob_address_out  out  ADDR_W  reported address.
- agu_rob_misalign_out  out  1  reported op is misaligned.
- rob_agu_rst_in  in  1  flush.
- agu_count_out  out  log2(DEPTH)+1  occupancy.

Function
REQ-006 Effective address SHALL be vj+a modulo 2^ADDR_W, computed at enqueue and stored with dest and opcode.
REQ-007 rs_agu_ready_out SHALL equal rdy_in && !rob_agu_rst_in && count<DEPTH; no same-cycle bypass when full.
REQ-008 An op SHALL enqueue at the edge where valid && ready and opcode is in `LB..`LHU or `SB..`SW; all other opcodes, including `NOP, SHALL be consumed without enqueue.
REQ-009 Minimum latency SHALL be 1 cycle: an op enqueued at edge N drives head outputs from edge N onward.
REQ-010 Head load: agu_lbuffer_valid_out=1; pop at the edge where lbuffer_agu_ready_in=1; hold all fields stable while stalled.
REQ-011 Head store: agu_rob_en_out=1 for exactly one cycle with tag and address; pop unconditionally at that edge.
REQ-012 Non-head entries SHALL never appear on outputs; order SHALL be strict FIFO across loads and stores.
REQ-013 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-014 Flush SHALL force all valid/en outputs low that cycle and, at the edge, empty the queue (pointers and count 0), discarding any same-cycle input.
REQ-015 rdy_in=0 SHALL hold all state, force valid/en outputs and ready low, and override flush and push.
REQ-016 When the queue is empty, all valid/en outputs SHALL be 0 and data outputs SHALL be 0.

Reset
REQ-017 While rst_in=1 at an edge, pointers, count and all entries SHALL clear; rst_in SHALL take priority over rdy_in and flush.
REQ-018 After reset, all outputs SHALL be 0 except rs_agu_ready_out, which SHALL follow REQ-007.

Configuration
REQ-019 With AGU_MISALIGN_CHECK_EN defined, halfword ops with addr[0]=1 and word ops with addr[1:0]!=0 SHALL be flagged at enqueue; at head, they SHALL be reported via agu_rob_en_out with agu_rob_misalign_out=1, popped, and never sent to the load buffer.
REQ-020 Without AGU_MISALIGN_CHECK_EN, agu_rob_misalign_out SHALL be tied 0 and alignment SHALL be ignored.

Verification
REQ-021 LW with vj=0x1000, a=0x10, dest=3 -> next cycle lbuffer valid, a=0x1010, dest=3; popped on ready.
REQ-022 SW with vj=0xFFFFFFFC, a=8, dest=5 -> one-cycle rob_en, h=5, address=0x4 (wrap).
REQ-023 Five loads with lbuffer ready held 0 -> ready drops after 4, count=4; raising ready drains in order.
REQ-024 Queue holding 3 entries, flush asserted concurrently with a valid push -> next cycle count=0, no outputs.
REQ-025 NOP with valid=1 -> no enqueue, count stays 0.
REQ-026 With macro: LH address 0x1001 -> rob_en=1, misalign=1, lbuffer valid stays 0; without macro -> load issued.
